// File: rtl/tt_um_waves.sv
// tt_um_waves: four-shape digital waveform generator (Tiny Tapeout wrapper).
//
// A 16-bit phase accumulator advances by ui_in[7:2] on every clock while ena
// is high. Its top byte indexes one of four shapers, selected by ui_in[1:0]:
// square, sawtooth, triangle or a quarter-wave-ROM sine. The chosen 8-bit
// unsigned sample is registered onto uo_out, one cycle behind the phase.
//
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   ena     - phase advance enable (output keeps updating from held phase)
//   ui_in   - [1:0] waveform select (00 sq, 01 saw, 10 tri, 11 sine),
//             [7:2] phase step 0..63
//   uo_out  - registered waveform sample
//   uio_in  - square-wave duty threshold
//   uio_out - sync output (bit 7) when WAVES_SYNC_EN is defined, else 0
//   uio_oe  - 8'h80 when WAVES_SYNC_EN is defined, else 8'h00
//
// Build option WAVES_SYNC_EN: drives a registered phase[15] sync square on
// uio_out[7] and narrows the duty threshold to uio_in[6:0].
module tt_um_waves (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [15:0] phase_q;
    logic [15:0] phase_d;
    logic [7:0]  sample_q;
    logic [7:0]  sample_d;
    logic [7:0]  p;
    logic [1:0]  wave_sel;
    logic [5:0]  step;
    logic [7:0]  duty;
    logic [5:0]  rom_idx;
    logic [6:0]  rom_val;

    assign p        = phase_q[15:8];
    assign wave_sel = ui_in[1:0];
    assign step     = ui_in[7:2];

    always_comb begin
        phase_d = phase_q;
        if (ena) begin
            phase_d = phase_q + {10'b0, step};
        end
    end

    // Quadrants 1 and 3 run the quarter wave backwards.
    assign rom_idx = p[6] ? ~p[5:0] : p[5:0];

    // Quarter-wave table: round(127*sin(2*pi*(i+0.5)/256)), i = 0..63.
    always_comb begin
        rom_val = 7'd0;
        case (rom_idx)
            6'd0:  rom_val = 7'd2;    6'd1:  rom_val = 7'd5;
            6'd2:  rom_val = 7'd8;    6'd3:  rom_val = 7'd11;
            6'd4:  rom_val = 7'd14;   6'd5:  rom_val = 7'd17;
            6'd6:  rom_val = 7'd20;   6'd7:  rom_val = 7'd23;
            6'd8:  rom_val = 7'd26;   6'd9:  rom_val = 7'd29;
            6'd10: rom_val = 7'd32;   6'd11: rom_val = 7'd35;
            6'd12: rom_val = 7'd38;   6'd13: rom_val = 7'd41;
            6'd14: rom_val = 7'd44;   6'd15: rom_val = 7'd47;
            6'd16: rom_val = 7'd50;   6'd17: rom_val = 7'd53;
            6'd18: rom_val = 7'd56;   6'd19: rom_val = 7'd58;
            6'd20: rom_val = 7'd61;   6'd21: rom_val = 7'd64;
            6'd22: rom_val = 7'd67;   6'd23: rom_val = 7'd69;
            6'd24: rom_val = 7'd72;   6'd25: rom_val = 7'd74;
            6'd26: rom_val = 7'd77;   6'd27: rom_val = 7'd79;
            6'd28: rom_val = 7'd82;   6'd29: rom_val = 7'd84;
            6'd30: rom_val = 7'd86;   6'd31: rom_val = 7'd89;
            6'd32: rom_val = 7'd91;   6'd33: rom_val = 7'd93;
            6'd34: rom_val = 7'd95;   6'd35: rom_val = 7'd97;
            6'd36: rom_val = 7'd99;   6'd37: rom_val = 7'd101;
            6'd38: rom_val = 7'd103;  6'd39: rom_val = 7'd105;
            6'd40: rom_val = 7'd106;  6'd41: rom_val = 7'd108;
            6'd42: rom_val = 7'd110;  6'd43: rom_val = 7'd111;
            6'd44: rom_val = 7'd113;  6'd45: rom_val = 7'd114;
            6'd46: rom_val = 7'd115;  6'd47: rom_val = 7'd117;
            6'd48: rom_val = 7'd118;  6'd49: rom_val = 7'd119;
            6'd50: rom_val = 7'd120;  6'd51: rom_val = 7'd121;
            6'd52: rom_val = 7'd122;  6'd53: rom_val = 7'd123;
            6'd54: rom_val = 7'd124;  6'd55: rom_val = 7'd124;
            6'd56: rom_val = 7'd125;  6'd57: rom_val = 7'd125;
            6'd58: rom_val = 7'd126;  6'd59: rom_val = 7'd126;
            default: rom_val = 7'd127;
        endcase
    end

    always_comb begin
        sample_d = 8'h00;
        case (wave_sel)
            2'b00: sample_d = (p < duty) ? 8'hFF : 8'h00;
            2'b01: sample_d = p;
            // Second half mirrors the ramp; the inversion makes it fall 255..1.
            2'b10: sample_d = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            default: sample_d = p[7] ? (8'd127 - {1'b0, rom_val})
                                     : (8'd128 + {1'b0, rom_val});
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= 16'h0000;
            sample_q <= 8'h00;
        end else begin
            phase_q  <= phase_d;
            sample_q <= sample_d;
        end
    end

    assign uo_out = sample_q;

`ifdef WAVES_SYNC_EN
    logic sync_q;
    logic unused_duty_msb;

    // Registered alongside the sample so the trigger lines up with uo_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= phase_q[15];
        end
    end

    assign duty            = {1'b0, uio_in[6:0]};
    assign unused_duty_msb = uio_in[7];
    assign uio_out         = {sync_q, 7'b0};
    assign uio_oe          = 8'h80;
`else
    assign duty    = uio_in;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_waves.sv
// Directed testbench for tt_um_waves: reset, sawtooth, triangle, sine,
// square, hold and asynchronous reset, with a reference model of the phase.
module tb_tt_um_waves;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_phase;
    logic [7:0]  exp_out;
    logic        exp_sync;
    logic [7:0]  last_p;

    tt_um_waves dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Sine reference computed directly from the sine function.
    function automatic logic [7:0] sine_ref(input logic [7:0] pv);
        real a;
        real s;
        int  q;
        a = 2.0 * 3.14159265358979 * (real'(pv) + 0.5) / 256.0;
        s = 127.0 * $sin(a);
        if (s < 0.0) s = -s;
        q = $rtoi(s + 0.5);
        if (pv < 8'd128) return 8'(128 + q);
        return 8'(127 - q);
    endfunction

    function automatic logic [7:0] model_sample(input logic [1:0] sel, input logic [7:0] pv,
                                                input logic [7:0] duty_in);
        logic [7:0] thr;
        int pi;
`ifdef WAVES_SYNC_EN
        thr = {1'b0, duty_in[6:0]};
`else
        thr = duty_in;
`endif
        pi = int'(pv);
        case (sel)
            2'b00:   return (pv < thr) ? 8'hFF : 8'h00;
            2'b01:   return pv;
            2'b10:   return (pi < 128) ? 8'(2 * pi) : 8'(511 - 2 * pi);
            default: return sine_ref(pv);
        endcase
    endfunction

    // One clock: model the edge, then compare all outputs at the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            m_phase  = 16'h0000;
            exp_out  = 8'h00;
            exp_sync = 1'b0;
            last_p   = 8'h00;
        end else begin
            last_p   = m_phase[15:8];
            exp_out  = model_sample(ui_in[1:0], last_p, uio_in);
            exp_sync = m_phase[15];
            if (ena) m_phase = m_phase + {10'b0, ui_in[7:2]};
        end
        @(negedge clk);
        check_val(tag, uo_out, exp_out);
`ifdef WAVES_SYNC_EN
        check_val("uio_oe", uio_oe, 8'h80);
        check_val("uio_out", uio_out, {exp_sync, 7'b0});
`else
        check_val("uio_oe", uio_oe, 8'h00);
        check_val("uio_out", uio_out, 8'h00);
`endif
    endtask

    // Run a full-period sweep and also compare four hand-computed points.
    task automatic sweep_spots(input string tag, input int cycles,
                               input logic [7:0] p0, input logic [7:0] v0,
                               input logic [7:0] p1, input logic [7:0] v1,
                               input logic [7:0] p2, input logic [7:0] v2,
                               input logic [7:0] p3, input logic [7:0] v3);
        logic [3:0] seen;
        seen = 4'b0;
        for (int i = 0; i < cycles; i++) begin
            tick(tag);
            if (!seen[0] && last_p == p0) begin check_val({tag, "_spot0"}, uo_out, v0); seen[0] = 1'b1; end
            if (!seen[1] && last_p == p1) begin check_val({tag, "_spot1"}, uo_out, v1); seen[1] = 1'b1; end
            if (!seen[2] && last_p == p2) begin check_val({tag, "_spot2"}, uo_out, v2); seen[2] = 1'b1; end
            if (!seen[3] && last_p == p3) begin check_val({tag, "_spot3"}, uo_out, v3); seen[3] = 1'b1; end
        end
        $display("section %s: %0d cycles, spots seen %b", tag, cycles, seen);
    endtask

    initial begin
        m_phase  = 16'h0000;
        exp_out  = 8'h00;
        exp_sync = 1'b0;
        last_p   = 8'h00;
        rst_n    = 1'b0;
        ena      = 1'b1;
        ui_in    = 8'hFF;
        uio_in   = 8'h40;

        // Reset held with clock running and an aggressive input pattern.
        for (int i = 0; i < 4; i++) tick("reset_hold");
        rst_n = 1'b1;
        ui_in = {6'd32, 2'b01};
        $display("section reset done");

        // Sawtooth, step 32: +1 every 8 clocks, wraps after 2048 clocks.
        for (int k = 1; k <= 2049; k++) begin
            tick("saw");
            if (k == 1)    check_val("saw_edge1", uo_out, 8'h00);
            if (k == 9)    check_val("saw_edge9", uo_out, 8'h01);
            if (k == 2048) check_val("saw_edge2048", uo_out, 8'hFF);
            if (k == 2049) check_val("saw_wrap", uo_out, 8'h00);
        end
        $display("section saw done");

        ui_in = {6'd63, 2'b10};
        sweep_spots("tri", 1100, 8'h40, 8'h80, 8'h7F, 8'hFE, 8'h80, 8'hFF, 8'hC0, 8'h7F);

        ui_in = {6'd63, 2'b11};
        sweep_spots("sine", 1100, 8'h00, 8'd130, 8'h40, 8'd255, 8'h80, 8'd125, 8'hC0, 8'd0);

        ui_in  = {6'd63, 2'b00};
        uio_in = 8'h40;
        sweep_spots("sq40", 1100, 8'h00, 8'hFF, 8'h3F, 8'hFF, 8'h40, 8'h00, 8'hFF, 8'h00);

        uio_in = 8'h00;
        sweep_spots("sq00", 1100, 8'h00, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00, 8'hFF, 8'h00);

        uio_in = 8'hFF;
`ifdef WAVES_SYNC_EN
        sweep_spots("sqFF", 1100, 8'h00, 8'hFF, 8'h7E, 8'hFF, 8'h7F, 8'h00, 8'hFF, 8'h00);
`else
        sweep_spots("sqFF", 1100, 8'h00, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'hFF);
`endif

        // Hold: ena low, then step 0; output must stay at the held phase.
        ui_in = {6'd32, 2'b01};
        for (int i = 0; i < 4; i++) tick("hold_run");
        ena = 1'b0;
        for (int i = 0; i < 6; i++) tick("hold_ena0");
        ena   = 1'b1;
        ui_in = {6'd0, 2'b01};
        for (int i = 0; i < 6; i++) tick("hold_step0");
        $display("section hold done");

        // Asynchronous reset in the middle of a clock cycle.
        ui_in = {6'd63, 2'b01};
        for (int i = 0; i < 20; i++) tick("pre_async");
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_out", uo_out, 8'h00);
        check_val("async_rst_uio", uio_out, 8'h00);
        m_phase = 16'h0000;
        tick("async_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick("post_async");
        $display("section async reset done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
